syn_fft_cache: RTL and testbench

SYN_FFT_CACHE -- requirements
Module: syn_fft_cache

---
 rtl/syn_fft_cache.sv | 152 +++++++++++++++
 tb/tb_syn_fft_cache.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/syn_fft_cache.sv
// Dual-port sample cache between an FFT engine and a host.
// Define SYN_FFT_CACHE_PINGPONG_EN for two ping-pong banks; otherwise one shared bank with FFT priority.
package syn_fft_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } fft_sample_t;
endpackage

module syn_fft_cache
  import syn_fft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  fft_sample_t       wr_sample,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_en,
  output fft_sample_t       rd_sample,
  output logic              rd_valid,
  input  logic              fft_done,
  input  logic [DATA_W-1:0] hst_wr_data,
  input  logic              hst_wr_en,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic              hst_rd_en,
  output logic [DATA_W-1:0] hst_rd_data,
  output logic              hst_rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] fft_wdata;
  logic [DATA_W-1:0] fft_rd_q;
  logic [DATA_W-1:0] hst_rd_q;
  logic              fft_rd_p;
  logic              hst_rd_p;
  logic              hst_rd_go;
  logic              hst_wr_go;

  assign fft_wdata = wr_sample;

  // Memory is sampled in the issue cycle so same-cycle writes are not visible (read-before-write).
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      fft_rd_p     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_sample    <= '0;
      hst_rd_p     <= 1'b0;
      hst_rd_valid <= 1'b0;
      hst_rd_data  <= '0;
    end else begin
      fft_rd_p     <= rd_en;
      rd_valid     <= fft_rd_p;
      hst_rd_p     <= hst_rd_go;
      hst_rd_valid <= hst_rd_p;
      if (fft_rd_p) rd_sample <= fft_rd_q;
      if (hst_rd_p) hst_rd_data <= hst_rd_q;
    end
  end

`ifdef SYN_FFT_CACHE_PINGPONG_EN

  logic              bank_sel;
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) bank_sel <= 1'b0;
    else if (fft_done) bank_sel <= ~bank_sel;
  end

  assign hst_wr_go = hst_wr_en;
  assign hst_rd_go = hst_rd_en & ~hst_wr_en;

  // FFT side owns bank_sel, host owns the other bank, so the two never collide.
  always_ff @(posedge clk_ir) begin
    if (wr_en) begin
      if (bank_sel) mem1[waddr] <= fft_wdata;
      else          mem0[waddr] <= fft_wdata;
    end
    if (hst_wr_go) begin
      if (bank_sel) mem0[hst_addr] <= hst_wr_data;
      else          mem1[hst_addr] <= hst_wr_data;
    end
    if (rd_en)     fft_rd_q <= bank_sel ? mem1[raddr] : mem0[raddr];
    if (hst_rd_go) hst_rd_q <= bank_sel ? mem0[hst_addr] : mem1[hst_addr];
  end

`else

  logic              fft_busy;
  logic              pend_v;
  logic              pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] hst_go_addr;
  logic [DATA_W-1:0] hst_go_data;
  logic              unused_fft_done;
  logic [DATA_W-1:0] mem [DEPTH];

  assign unused_fft_done = fft_done;
  assign fft_busy        = wr_en | rd_en;

  // Host runs only in FFT-idle cycles; a parked request takes precedence over a fresh one.
  always_comb begin
    hst_wr_go   = 1'b0;
    hst_rd_go   = 1'b0;
    hst_go_addr = hst_addr;
    hst_go_data = hst_wr_data;
    if (!fft_busy) begin
      if (pend_v) begin
        hst_wr_go   = pend_wr;
        hst_rd_go   = ~pend_wr;
        hst_go_addr = pend_addr;
        hst_go_data = pend_data;
      end else begin
        hst_wr_go = hst_wr_en;
        hst_rd_go = hst_rd_en & ~hst_wr_en;
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      pend_v    <= 1'b0;
      pend_wr   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (!fft_busy) begin
      pend_v <= 1'b0;
    end else if (!pend_v && (hst_wr_en || hst_rd_en)) begin
      pend_v    <= 1'b1;
      pend_wr   <= hst_wr_en;
      pend_addr <= hst_addr;
      pend_data <= hst_wr_data;
    end
  end

  always_ff @(posedge clk_ir) begin
    if (wr_en)          mem[waddr] <= fft_wdata;
    else if (hst_wr_go) mem[hst_go_addr] <= hst_go_data;
    if (rd_en)     fft_rd_q <= mem[raddr];
    if (hst_rd_go) hst_rd_q <= mem[hst_go_addr];
  end

`endif

endmodule

// File: tb/tb_syn_fft_cache.sv
// Scoreboard bench for syn_fft_cache: driver predicts responses from a bank/pending model, monitor checks them.
module tb_syn_fft_cache;
  import syn_fft_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef SYN_FFT_CACHE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk_ir = 1'b0;
  logic          rst_il = 1'b1;
  fft_sample_t   wr_sample;
  fft_sample_t   rd_sample;
  logic          wr_en, rd_en, rd_valid, fft_done;
  logic          hst_wr_en, hst_rd_en, hst_rd_valid;
  logic [AW-1:0] waddr, raddr, hst_addr;
  logic [DW-1:0] hst_wr_data, hst_rd_data;

  syn_fft_cache #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_ir(clk_ir), .rst_il(rst_il),
    .wr_sample(wr_sample), .wr_en(wr_en), .waddr(waddr),
    .raddr(raddr), .rd_en(rd_en), .rd_sample(rd_sample), .rd_valid(rd_valid),
    .fft_done(fft_done),
    .hst_wr_data(hst_wr_data), .hst_wr_en(hst_wr_en), .hst_addr(hst_addr),
    .hst_rd_en(hst_rd_en), .hst_rd_data(hst_rd_data), .hst_rd_valid(hst_rd_valid)
  );

  always #5 clk_ir = ~clk_ir;

  int cyc = 0;
  always @(posedge clk_ir) cyc++;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t fq[$];
  exp_t hq[$];
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] mem_m [2][DEPTH];
  bit            bsel_m  = 1'b0;
  bit            pend_v  = 1'b0;
  bit            pend_wr = 1'b0;
  logic [AW-1:0] pend_a  = '0;
  logic [DW-1:0] pend_d  = '0;
  logic [DW-1:0] last_f  = '0;
  logic [DW-1:0] last_h  = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_ir) begin
    exp_t e;
    if (rst_il) begin
      if (rd_valid) begin
        if (fq.size() == 0) chk("rd_unexpected", rd_valid, 0);
        else begin
          e = fq.pop_front();
          chk("rd_data", rd_sample, e.d);
          chk("rd_latency", cyc, e.due);
          last_f = e.d;
        end
      end else chk("rd_hold", rd_sample, last_f);
      if (hst_rd_valid) begin
        if (hq.size() == 0) chk("hst_unexpected", hst_rd_valid, 0);
        else begin
          e = hq.pop_front();
          chk("hst_data", hst_rd_data, e.d);
          chk("hst_latency", cyc, e.due);
          last_h = e.d;
        end
      end else chk("hst_hold", hst_rd_data, last_h);
    end
  end

  // One clock cycle of stimulus; the model settles reads before writes and owns bank/pending state.
  task automatic step(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit r, input logic [AW-1:0] ra,
                      input bit hw, input bit hr, input logic [AW-1:0] ha,
                      input logic [DW-1:0] hd, input bit dn);
    bit            fb, hb, ex_w, ex_r;
    logic [AW-1:0] ex_a;
    logic [DW-1:0] ex_d;
    wr_en = w; waddr = wa; wr_sample = wd; rd_en = r; raddr = ra;
    hst_wr_en = hw; hst_rd_en = hr; hst_addr = ha; hst_wr_data = hd; fft_done = dn;
    fb   = PP ? bsel_m : 1'b0;
    hb   = PP ? !bsel_m : 1'b0;
    ex_w = 1'b0; ex_r = 1'b0; ex_a = ha; ex_d = hd;
    if (PP) begin
      ex_w = hw; ex_r = hr && !hw;
    end else if (!(w || r)) begin
      if (pend_v) begin
        ex_w = pend_wr; ex_r = !pend_wr; ex_a = pend_a; ex_d = pend_d; pend_v = 1'b0;
      end else begin
        ex_w = hw; ex_r = hr && !hw;
      end
    end else if (!pend_v && (hw || hr)) begin
      pend_v = 1'b1; pend_wr = hw; pend_a = ha; pend_d = hd;
    end
    if (r)    fq.push_back('{mem_m[fb][ra], cyc + 2});
    if (ex_r) hq.push_back('{mem_m[hb][ex_a], cyc + 2});
    if (w)    mem_m[fb][wa] = wd;
    if (ex_w) mem_m[hb][ex_a] = ex_d;
    if (PP && dn) bsel_m = !bsel_m;
    @(posedge clk_ir); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset(input int hold);
    wr_en = 0; rd_en = 0; hst_wr_en = 0; hst_rd_en = 0; fft_done = 0;
    rst_il = 1'b0;
    #1;
    fq.delete(); hq.delete();
    bsel_m = 1'b0; pend_v = 1'b0; last_f = '0; last_h = '0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_hst_rd_valid", hst_rd_valid, 0);
    chk("rst_rd_sample", rd_sample, 0);
    chk("rst_hst_rd_data", hst_rd_data, 0);
`ifdef SYN_FFT_CACHE_PINGPONG_EN
    chk("rst_bank_sel", dut.bank_sel, 0);
`endif
    repeat (hold) @(posedge clk_ir);
    #1 rst_il = 1'b1;
  endtask

  initial begin
    wr_en = 0; rd_en = 0; hst_wr_en = 0; hst_rd_en = 0; fft_done = 0;
    waddr = '0; raddr = '0; hst_addr = '0; hst_wr_data = '0; wr_sample = '0;
    #2;
    do_reset(3);

    for (int a = 0; a < DEPTH; a++)
      step(1, AW'(a), $urandom, 0, '0, 0, 0, '0, '0, PP && (a == DEPTH - 1));
    for (int a = 0; a < DEPTH; a++)
      step(1, AW'(a), $urandom, 0, '0, 0, 0, '0, '0, PP && (a == DEPTH - 1));
    idle(2);

    // basic write then read, 2-cycle latency
    step(1, 8'h05, 32'h12345678, 0, '0, 0, 0, '0, '0, 0);
    step(0, '0, '0, 1, 8'h05, 0, 0, '0, '0, 0);
    idle(3);

    // read-before-write on the FFT port
    step(1, 8'h07, 32'h11110000, 0, '0, 0, 0, '0, '0, 0);
    step(1, 8'h07, 32'hBEEF0000, 1, 8'h07, 0, 0, '0, '0, 0);
    step(0, '0, '0, 1, 8'h07, 0, 0, '0, '0, 0);
    idle(3);

    // bank handover: host sees FFT data only after fft_done
    step(1, 8'h03, 32'hAAAA0001, 0, '0, 0, 1, 8'h03, '0, 0);
    idle(2);
    step(0, '0, '0, 0, '0, 0, 0, '0, '0, 1);
    step(0, '0, '0, 0, '0, 0, 1, 8'h03, '0, 0);
    idle(3);

    // host read against a busy FFT port, second host read dropped in shared mode
    step(0, '0, '0, 1, 8'h01, 0, 1, 8'h09, '0, 0);
    step(0, '0, '0, 1, 8'h02, 0, 1, 8'h0A, '0, 0);
    step(0, '0, '0, 1, 8'h03, 0, 0, '0, '0, 0);
    step(0, '0, '0, 1, 8'h04, 0, 0, '0, '0, 0);
    idle(4);

    // host write+read same cycle performs the write only
    step(0, '0, '0, 0, '0, 1, 1, 8'h20, 32'hCAFE0020, 0);
    step(0, '0, '0, 0, '0, 0, 1, 8'h20, '0, 0);
    idle(3);

    // reset one cycle after a read: nothing returns, bank_sel back to 0
    step(0, '0, '0, 0, '0, 0, 0, '0, '0, 1);
    step(0, '0, '0, 1, 8'h05, 0, 1, 8'h05, '0, 0);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_rd_valid", rd_valid, 0);
      chk("post_rst_hst_valid", hst_rd_valid, 0);
`ifdef SYN_FFT_CACHE_PINGPONG_EN
      chk("post_rst_bank_sel", dut.bank_sel, 0);
`endif
      idle(1);
    end

    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] m;
      m = ($urandom_range(0, 3) != 0) ? 8'h0F : 8'hFF;
      if (i == 1500) do_reset(1);
      step($urandom_range(0, 2) == 0, AW'($urandom) & m, $urandom,
           $urandom_range(0, 2) == 0, AW'($urandom) & m,
           $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, AW'($urandom) & m,
           $urandom, $urandom_range(0, 30) == 0);
    end

    idle(10);
    chk("fft_drain", fq.size(), 0);
    chk("host_drain", hq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=%0d required=<200000", cyc);
    $fatal(1, "timeout");
  end

endmodule
